// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------------
// | Module   : cpu_pkg
// | Brief    : Shared widths and pipeline-stage state encoding.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 4;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // A request carrying both enables is treated as a store.
  function automatic logic is_store_req(input logic store_en, input logic load_en);
    is_store_req = store_en | (store_en & load_en);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory.sv
// +----------------------------------------------------------------------------
// | Module   : data_memory
// | Brief    : Single-port data array, synchronous write, asynchronous read.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module data_memory #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [c_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/memory_writeback_stage.sv
// +----------------------------------------------------------------------------
// | Module   : memory_writeback_stage
// | Brief    : Memory access and register-file write-back with wait states.
// |            Define DMEM_CLEAR_EN to zero the data memory after reset.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module memory_writeback_stage #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int REG_ADDR_W = 4,
  parameter int MEM_WAIT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     result,
  input  logic [REG_ADDR_W-1:0] reg_addr,
  input  logic                  write_enable,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic                  store_enable,
  input  logic                  load_enable,
  output logic                  stall,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0]     rf_write_data
);

  import cpu_pkg::*;

  localparam logic [2:0] c_WAIT      = 3'(MEM_WAIT);
  localparam logic       c_ZERO_WAIT = (MEM_WAIT == 0);
`ifdef DMEM_CLEAR_EN
  localparam state_e     c_RST_STATE = CLEAR;
`else
  localparam state_e     c_RST_STATE = IDLE;
`endif

  state_e                r_state;
  state_e                w_state_nxt;
  logic [2:0]            r_cnt;
  logic [2:0]            w_cnt_nxt;

  logic [DATA_W-1:0]     r_lat_result;
  logic [REG_ADDR_W-1:0] r_lat_reg_addr;
  logic [ADDR_W-1:0]     r_lat_mem_addr;
  logic                  r_lat_we;
  logic                  r_lat_store;
  logic                  w_latch;

  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0]     r_rf_data;
  logic                  w_rf_we_nxt;
  logic [REG_ADDR_W-1:0] w_rf_addr_nxt;
  logic [DATA_W-1:0]     w_rf_data_nxt;

  logic                  w_mem_req;
  logic                  w_req_store;
  logic                  w_mem_we;
  logic [ADDR_W-1:0]     w_mem_addr;
  logic [DATA_W-1:0]     w_mem_wdata;
  logic [DATA_W-1:0]     w_mem_rdata;
  logic                  w_stall;

`ifdef DMEM_CLEAR_EN
  logic [ADDR_W-1:0]     r_clr_addr;
  logic [ADDR_W-1:0]     w_clr_nxt;
`endif

  assign w_mem_req   = store_enable | load_enable;
  assign w_req_store = is_store_req(store_enable, load_enable);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_latch       = 1'b0;
    w_stall       = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_addr    = mem_addr;
    w_mem_wdata   = result;
    w_rf_we_nxt   = 1'b0;
    w_rf_addr_nxt = r_rf_addr;
    w_rf_data_nxt = r_rf_data;
`ifdef DMEM_CLEAR_EN
    w_clr_nxt     = r_clr_addr;
`endif

    case (r_state)
      IDLE: begin
        if (w_mem_req) begin
          if (c_ZERO_WAIT) begin
            w_mem_we = w_req_store;
            if (!w_req_store) begin
              w_rf_we_nxt   = write_enable;
              w_rf_addr_nxt = reg_addr;
              w_rf_data_nxt = w_mem_rdata;
            end
          end else begin
            w_latch     = 1'b1;
            w_cnt_nxt   = c_WAIT;
            w_state_nxt = BUSY;
            w_stall     = 1'b1;
          end
        end else begin
          w_rf_we_nxt   = write_enable;
          w_rf_addr_nxt = reg_addr;
          w_rf_data_nxt = result;
        end
      end

      BUSY: begin
        // Upstream inputs are ignored here; only the latched request matters.
        w_mem_addr  = r_lat_mem_addr;
        w_mem_wdata = r_lat_result;
        w_cnt_nxt   = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_state_nxt = IDLE;
          w_mem_we    = r_lat_store;
          if (!r_lat_store) begin
            w_rf_we_nxt   = r_lat_we;
            w_rf_addr_nxt = r_lat_reg_addr;
            w_rf_data_nxt = w_mem_rdata;
          end
        end else begin
          w_stall = 1'b1;
        end
      end

      CLEAR: begin
`ifdef DMEM_CLEAR_EN
        w_stall     = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_addr;
        w_mem_wdata = '0;
        w_clr_nxt   = r_clr_addr + 1'b1;
        if (r_clr_addr == '1) begin
          w_state_nxt = IDLE;
        end
`else
        w_state_nxt = IDLE;
`endif
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= c_RST_STATE;
      r_cnt          <= '0;
      r_rf_we        <= 1'b0;
      r_rf_addr      <= '0;
      r_rf_data      <= '0;
      r_lat_result   <= '0;
      r_lat_reg_addr <= '0;
      r_lat_mem_addr <= '0;
      r_lat_we       <= 1'b0;
      r_lat_store    <= 1'b0;
`ifdef DMEM_CLEAR_EN
      r_clr_addr     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rf_we   <= w_rf_we_nxt;
      r_rf_addr <= w_rf_addr_nxt;
      r_rf_data <= w_rf_data_nxt;
      if (w_latch) begin
        r_lat_result   <= result;
        r_lat_reg_addr <= reg_addr;
        r_lat_mem_addr <= mem_addr;
        r_lat_we       <= write_enable;
        r_lat_store    <= w_req_store;
      end
`ifdef DMEM_CLEAR_EN
      r_clr_addr <= w_clr_nxt;
`endif
    end
  end

  // Reset aborts any write that would otherwise land on the same edge.
  data_memory #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we & ~reset),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign stall           = w_stall;
  assign rf_write_enable = r_rf_we;
  assign rf_write_addr   = r_rf_addr;
  assign rf_write_data   = r_rf_data;

endmodule

`default_nettype wire

// File: tb/tb_memory_writeback_stage.sv
// +----------------------------------------------------------------------------
// | Module   : tb_memory_writeback_stage
// | Brief    : Directed bench for memory_writeback_stage (MEM_WAIT 2 and 0).
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tb_memory_writeback_stage;

`ifdef DMEM_CLEAR_EN
  localparam logic c_RST_STALL = 1'b1;
  localparam logic c_CLR       = 1'b1;
`else
  localparam logic c_RST_STALL = 1'b0;
  localparam logic c_CLR       = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] result;
  logic [3:0]  reg_addr;
  logic        write_enable;
  logic [3:0]  mem_addr;
  logic        store_enable;
  logic        load_enable;
  logic        stall;
  logic        rf_we;
  logic [3:0]  rf_addr;
  logic [15:0] rf_data;

  logic [15:0] result_z;
  logic [3:0]  reg_addr_z;
  logic        write_enable_z;
  logic [3:0]  mem_addr_z;
  logic        store_enable_z;
  logic        load_enable_z;
  logic        stall_z;
  logic        rf_we_z;
  logic [3:0]  rf_addr_z;
  logic [15:0] rf_data_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_writeback_stage #(.DATA_W(16), .ADDR_W(4), .REG_ADDR_W(4), .MEM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .result(result), .reg_addr(reg_addr),
    .write_enable(write_enable), .mem_addr(mem_addr), .store_enable(store_enable),
    .load_enable(load_enable), .stall(stall), .rf_write_enable(rf_we),
    .rf_write_addr(rf_addr), .rf_write_data(rf_data)
  );

  memory_writeback_stage #(.DATA_W(16), .ADDR_W(4), .REG_ADDR_W(4), .MEM_WAIT(0)) dut_z (
    .clk(clk), .reset(reset), .result(result_z), .reg_addr(reg_addr_z),
    .write_enable(write_enable_z), .mem_addr(mem_addr_z), .store_enable(store_enable_z),
    .load_enable(load_enable_z), .stall(stall_z), .rf_write_enable(rf_we_z),
    .rf_write_addr(rf_addr_z), .rf_write_data(rf_data_z)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  ra;
    logic        we;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [15:0] exp_data;
  } alu_vec_t;

  alu_vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic nop();
    result = '0; reg_addr = '0; write_enable = 1'b0;
    mem_addr = '0; store_enable = 1'b0; load_enable = 1'b0;
  endtask

  // Presents one memory request and walks its MEM_WAIT+1 occupancy.
  task automatic mem_access(input string nm, input logic [15:0] res, input logic [3:0] ra,
                            input logic we, input logic [3:0] ma, input logic se,
                            input logic le, input logic exp_we, input logic [15:0] exp_data);
    result = res; reg_addr = ra; write_enable = we;
    mem_addr = ma; store_enable = se; load_enable = le;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk({nm, "_stall"}, 32'(stall), 32'(k < 2));
      if (k > 0) chk({nm, "_busy_we"}, 32'(rf_we), 32'(0));
      @(posedge clk); #1;
    end
    chk({nm, "_we"}, 32'(rf_we), 32'(exp_we));
    if (exp_we) begin
      chk({nm, "_addr"}, 32'(rf_addr), 32'(ra));
      chk({nm, "_data"}, 32'(rf_data), 32'(exp_data));
    end
  endtask

  // Waits out the post-reset clear sweep when it is built in.
  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    for (int k = 0; k < 40 && stall; k++) begin
      n++;
      @(posedge clk); #1;
    end
    chk({nm, "_clear_len"}, 32'(n), c_CLR ? 32'(16) : 32'(0));
  endtask

  initial begin
    int n, n_z;
    vecs[0] = '{16'h1234, 4'd3,  1'b1, 1'b1, 4'd3,  16'h1234};
    vecs[1] = '{16'h5555, 4'd5,  1'b0, 1'b0, 4'd5,  16'h5555};
    vecs[2] = '{16'hFFFF, 4'd15, 1'b1, 1'b1, 4'd15, 16'hFFFF};
    vecs[3] = '{16'h0000, 4'd0,  1'b1, 1'b1, 4'd0,  16'h0000};
    vecs[4] = '{16'h8001, 4'd9,  1'b1, 1'b1, 4'd9,  16'h8001};

    reset = 1'b1;
    nop();
    result_z = '0; reg_addr_z = '0; write_enable_z = 1'b0;
    mem_addr_z = '0; store_enable_z = 1'b0; load_enable_z = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'(0));
    chk("rst_rf_addr", 32'(rf_addr), 32'(0));
    chk("rst_rf_data", 32'(rf_data), 32'(0));
    chk("rst_stall", 32'(stall), 32'(c_RST_STALL));
    chk("rst_stall_z", 32'(stall_z), 32'(c_RST_STALL));
    chk("rst_rf_we_z", 32'(rf_we_z), 32'(0));
    reset = 1'b0;

    n = 0; n_z = 0;
    for (int k = 0; k < 40; k++) begin
      if (stall) n++;
      if (stall_z) n_z++;
      @(posedge clk); #1;
    end
    chk("clear_stall_cycles", 32'(n), c_CLR ? 32'(16) : 32'(0));
    chk("clear_stall_cycles_z", 32'(n_z), c_CLR ? 32'(16) : 32'(0));

`ifdef DMEM_CLEAR_EN
    mem_access("clr_ld9", 16'hDEAD, 4'd4, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 16'h0000);
    reg_addr_z = 4'd4; write_enable_z = 1'b1; mem_addr_z = 4'd9; load_enable_z = 1'b1;
    @(posedge clk); #1;
    chk("z_clr_ld9_we", 32'(rf_we_z), 32'(1));
    chk("z_clr_ld9_data", 32'(rf_data_z), 32'(16'h0000));
    load_enable_z = 1'b0; write_enable_z = 1'b0;
`endif

    // Zero-wait instance: store then immediate load of the top address.
    result_z = 16'hA5A5; mem_addr_z = 4'd15; store_enable_z = 1'b1; write_enable_z = 1'b1;
    #1 chk("z_st_stall", 32'(stall_z), 32'(0));
    @(posedge clk); #1;
    chk("z_st_no_we", 32'(rf_we_z), 32'(0));
    result_z = 16'h0000; reg_addr_z = 4'd1; store_enable_z = 1'b0; load_enable_z = 1'b1;
    #1 chk("z_ld_stall", 32'(stall_z), 32'(0));
    @(posedge clk); #1;
    chk("z_ld_we", 32'(rf_we_z), 32'(1));
    chk("z_ld_addr", 32'(rf_addr_z), 32'(1));
    chk("z_ld_data", 32'(rf_data_z), 32'(16'hA5A5));
    load_enable_z = 1'b0; write_enable_z = 1'b0;
    @(posedge clk); #1;
    chk("z_ld_pulse_end", 32'(rf_we_z), 32'(0));

    for (int i = 0; i < 5; i++) begin
      result = vecs[i].res; reg_addr = vecs[i].ra; write_enable = vecs[i].we;
      mem_addr = 4'(i); store_enable = 1'b0; load_enable = 1'b0;
      #1 chk($sformatf("alu%0d_stall", i), 32'(stall), 32'(0));
      @(posedge clk); #1;
      chk($sformatf("alu%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
      chk($sformatf("alu%0d_addr", i), 32'(rf_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("alu%0d_data", i), 32'(rf_data), 32'(vecs[i].exp_data));
    end

    mem_access("st5", 16'hBEEF, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 16'h0000);
    mem_access("ld5", 16'h0000, 4'd7, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 16'hBEEF);
    mem_access("both", 16'h00FF, 4'd6, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 16'h0000);
    mem_access("ld2", 16'h0000, 4'd6, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 16'h00FF);
    mem_access("st15", 16'h1111, 4'd3, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 16'h0000);
    mem_access("ld15", 16'h0000, 4'd2, 1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 16'h1111);
    mem_access("ld_nowe", 16'h0000, 4'd9, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 16'h0000);
    nop();
    @(posedge clk); #1;
    chk("post_ld_we", 32'(rf_we), 32'(0));

    // Reset in the first BUSY cycle of a store: the write must not land.
    result = 16'h2222; mem_addr = 4'd5; store_enable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    nop();
    #1;
    chk("rst_st_stall", 32'(stall), 32'(c_RST_STALL));
    chk("rst_st_we", 32'(rf_we), 32'(0));
    wait_clear("rst_st");
    mem_access("ld5_after_rst", 16'h0000, 4'd7, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1,
               c_CLR ? 16'h0000 : 16'hBEEF);

    // Reset in the first BUSY cycle of a load: no write-back pulse, ever.
    result = 16'h0000; reg_addr = 4'd8; write_enable = 1'b1; mem_addr = 4'd15; load_enable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    nop();
    #1;
    chk("rst_ld_stall", 32'(stall), 32'(c_RST_STALL));
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (rf_we) n++;
      @(posedge clk); #1;
    end
    chk("rst_ld_no_pulse", 32'(n), 32'(0));
    chk("rst_ld_idle_stall", 32'(stall), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
